// File: rtl/crc_pkg.sv
// Shared types and constants for the streaming CRC encoder and its companion checker.
package crc_pkg;

    typedef enum logic {
        ST_DATA,
        ST_APPEND
    } state_t;

    localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
    localparam logic [31:0] CRC32_POLY       = 32'h04C11DB7;

    // A CRC must be emitted as a whole number of beats.
    function automatic bit crc_cfg_ok(input int unsigned crc_w, input int unsigned data_w);
        return (data_w != 0) && (crc_w >= 3) && ((crc_w % data_w) == 0);
    endfunction

endpackage

// File: rtl/crc_update.sv
// One-beat CRC update: DATA_W bits folded in MSB first, fully unrolled.
module crc_update
    import crc_pkg::*;
#(
    parameter int unsigned      DATA_W = 8,
    parameter int unsigned      CRC_W  = 16,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'(CRC16_CCITT_POLY)
) (
    input  logic [CRC_W-1:0]  crc,
    input  logic [DATA_W-1:0] data,
    output logic [CRC_W-1:0]  crc_next_c
);

    always_comb begin
        logic [CRC_W-1:0] acc;
        logic             fb;
        acc = crc;
        fb  = 1'b0;
        for (int i = int'(DATA_W) - 1; i >= 0; i--) begin
            fb  = acc[CRC_W-1] ^ data[i];
            acc = {acc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        crc_next_c = acc;
    end

endmodule

// File: rtl/crc_stream_encoder.sv
// Pass-through packet stream that appends the packet CRC as trailing beats.
module crc_stream_encoder
    import crc_pkg::*;
#(
    parameter int unsigned      DATA_W  = 8,
    parameter int unsigned      CRC_W   = 16,
    parameter logic [CRC_W-1:0] POLY    = CRC_W'(CRC16_CCITT_POLY),
    parameter logic [CRC_W-1:0] INIT    = '1,
    parameter logic [CRC_W-1:0] XOR_OUT = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              m_is_crc
);

    localparam int unsigned CRC_BEATS = CRC_W / DATA_W;
    localparam int unsigned CNT_W     = (CRC_BEATS > 1) ? $clog2(CRC_BEATS) : 1;

    if (!crc_cfg_ok(CRC_W, DATA_W)) begin : g_bad_cfg
        $error("crc_stream_encoder: CRC_W must be >= 3 and a multiple of DATA_W");
    end

    state_t             state;
    logic [CRC_W-1:0]   crc;
    logic [CRC_W-1:0]   crc_next_c;
    logic [CRC_W-1:0]   sreg;
    logic [CNT_W-1:0]   cnt;
    logic               slot_free_c;
    logic               in_xfer_c;

    crc_update #(
        .DATA_W (DATA_W),
        .CRC_W  (CRC_W),
        .POLY   (POLY)
    ) u_update (
        .crc        (crc),
        .data       (s_data),
        .crc_next_c (crc_next_c)
    );

    // Output slot can be (re)loaded when empty or being drained this cycle.
    assign slot_free_c = !m_valid || m_ready;
    assign s_ready     = (state == ST_DATA) && slot_free_c;
    assign in_xfer_c   = s_valid && s_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_DATA;
            crc      <= INIT;
            sreg     <= '0;
            cnt      <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_last   <= 1'b0;
            m_is_crc <= 1'b0;
        end else begin
            case (state)
                ST_DATA: begin
                    if (in_xfer_c) begin
                        m_data   <= s_data;
                        m_valid  <= 1'b1;
                        m_last   <= 1'b0;
                        m_is_crc <= 1'b0;
                        crc      <= crc_next_c;
                        if (s_last) begin
                            sreg  <= crc_next_c ^ XOR_OUT;
                            cnt   <= CNT_W'(CRC_BEATS - 1);
                            state <= ST_APPEND;
                        end
                    end else if (m_ready) begin
                        m_valid <= 1'b0;
                    end
                end
                ST_APPEND: begin
                    // CRC leaves MSB first, one beat per free slot.
                    if (slot_free_c) begin
                        m_data   <= sreg[CRC_W-1 -: DATA_W];
                        m_valid  <= 1'b1;
                        m_is_crc <= 1'b1;
                        m_last   <= (cnt == '0);
                        sreg     <= sreg << DATA_W;
                        if (cnt == '0) begin
                            state <= ST_DATA;
                            crc   <= INIT;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                default: state <= ST_DATA;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_stream_encoder.sv
// Scoreboard bench for crc_stream_encoder: CRC-16 byte stream, CRC-32 byte stream, CRC-16 word stream.
module tb_crc_stream_encoder;
    import crc_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: CRC-16/CCITT-FALSE, byte beats
    logic        a_s_valid = 1'b0, a_s_last = 1'b0, a_m_ready = 1'b1;
    logic [7:0]  a_s_data = '0;
    logic        a_s_ready, a_m_valid, a_m_last, a_m_is_crc;
    logic [7:0]  a_m_data;
    // Instance B: CRC-32/BZIP2, byte beats
    logic        b_s_valid = 1'b0, b_s_last = 1'b0, b_m_ready = 1'b1;
    logic [7:0]  b_s_data = '0;
    logic        b_s_ready, b_m_valid, b_m_last, b_m_is_crc;
    logic [7:0]  b_m_data;
    // Instance C: CRC-16/CCITT-FALSE, 16-bit beats
    logic        c_s_valid = 1'b0, c_s_last = 1'b0, c_m_ready = 1'b1;
    logic [15:0] c_s_data = '0;
    logic        c_s_ready, c_m_valid, c_m_last, c_m_is_crc;
    logic [15:0] c_m_data;

    crc_stream_encoder u_a (
        .clk(clk), .reset_n(reset_n),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data), .s_last(a_s_last),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data), .m_last(a_m_last),
        .m_is_crc(a_m_is_crc)
    );

    crc_stream_encoder #(
        .DATA_W(8), .CRC_W(32), .POLY(CRC32_POLY), .INIT(32'hFFFF_FFFF), .XOR_OUT(32'hFFFF_FFFF)
    ) u_b (
        .clk(clk), .reset_n(reset_n),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data), .s_last(b_s_last),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .m_last(b_m_last),
        .m_is_crc(b_m_is_crc)
    );

    crc_stream_encoder #(
        .DATA_W(16), .CRC_W(16)
    ) u_c (
        .clk(clk), .reset_n(reset_n),
        .s_valid(c_s_valid), .s_ready(c_s_ready), .s_data(c_s_data), .s_last(c_s_last),
        .m_valid(c_m_valid), .m_ready(c_m_ready), .m_data(c_m_data), .m_last(c_m_last),
        .m_is_crc(c_m_is_crc)
    );

    typedef struct {
        int          len;
        logic [71:0] bytes;
        logic [15:0] crc;
        bit          gaps;
        bit          drain;
    } vec_t;

    vec_t        vecs [6];
    logic [31:0] exp_a [$];
    logic [31:0] exp_b [$];
    logic [31:0] exp_c [$];
    logic        a_rand = 1'b0;
    logic        a_stall = 1'b0;
    logic [31:0] a_cur, a_held, a_e, b_e, c_e;
    int          a_left = 0;
    int          a_t0 = 0;
    int          a_last_pop_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic [15:0] d, input logic l, input logic c);
        return {14'b0, c, l, d};
    endfunction

    // Bit-serial CRC-16/CCITT-FALSE over the first n bytes of a left-aligned vector.
    function automatic logic [15:0] ccitt_model(input int n, input logic [71:0] bytes);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            for (int j = 7; j >= 0; j--) begin
                fb = c[15] ^ bytes[64 - 8*i + j];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        end
        return c;
    endfunction

    always @(posedge clk) begin
        #1;
        a_m_ready = a_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_a.delete();
            a_left  = 0;
            a_stall = 1'b0;
        end else begin
            a_cur = pk(16'(a_m_data), a_m_last, a_m_is_crc) | {a_m_valid, 31'b0};
            if (a_stall) check("a_hold_while_stalled", a_cur, a_held);
            a_stall = a_m_valid && !a_m_ready;
            a_held  = a_cur;
            if (a_m_valid && a_m_ready) begin
                if (exp_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected_beat: got %h expected none", a_cur);
                end else begin
                    a_e = exp_a.pop_front();
                    check("a_beat", a_cur & 32'h7FFF_FFFF, a_e);
                    if (a_e[16]) a_last_pop_cyc = cyc;
                end
            end
            if (a_left > 0) begin
                check("a_s_ready_in_append", 32'(a_s_ready), 32'd0);
                if (!a_m_valid || a_m_ready) a_left--;
            end
            if (a_s_valid && a_s_ready && a_s_last) a_left = 2;
        end
    end

    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_b.delete();
            exp_c.delete();
        end else begin
            if (b_m_valid && b_m_ready) begin
                if (exp_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected_beat: got %h expected none", b_m_data);
                end else begin
                    b_e = exp_b.pop_front();
                    check("b_beat", pk(16'(b_m_data), b_m_last, b_m_is_crc), b_e);
                end
            end
            if (c_m_valid && c_m_ready) begin
                if (exp_c.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL c_unexpected_beat: got %h expected none", c_m_data);
                end else begin
                    c_e = exp_c.pop_front();
                    check("c_beat", pk(c_m_data, c_m_last, c_m_is_crc), c_e);
                end
            end
        end
    end

    task automatic send_a(input int len, input logic [71:0] bytes, input logic [15:0] crc,
                          input bit gaps, input bit partial);
        bit ok;
        for (int i = 0; i < len; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            a_s_valid = 1'b1;
            a_s_data  = bytes[71 - 8*i -: 8];
            a_s_last  = (i == len - 1) && !partial;
            ok = 1'b0;
            for (int w = 0; w < 200 && !ok; w++) begin
                @(negedge clk);
                ok = a_s_ready;
                if (!ok) begin @(posedge clk); #1; end
            end
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL a_input_timeout: got s_ready=0 expected 1 within 200 cycles");
            end else begin
                if (i == 0) a_t0 = cyc;
                exp_a.push_back(pk(16'(a_s_data), 1'b0, 1'b0));
                if (a_s_last) begin
                    exp_a.push_back(pk(16'(crc[15:8]), 1'b0, 1'b1));
                    exp_a.push_back(pk(16'(crc[7:0]), 1'b1, 1'b1));
                end
            end
            @(posedge clk); #1;
            a_s_valid = 1'b0;
            a_s_last  = 1'b0;
        end
    endtask

    task automatic send_b(input int len, input logic [71:0] bytes, input logic [31:0] crc);
        bit ok;
        for (int i = 0; i < len; i++) begin
            b_s_valid = 1'b1;
            b_s_data  = bytes[71 - 8*i -: 8];
            b_s_last  = (i == len - 1);
            ok = 1'b0;
            for (int w = 0; w < 200 && !ok; w++) begin
                @(negedge clk);
                ok = b_s_ready;
                if (!ok) begin @(posedge clk); #1; end
            end
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL b_input_timeout: got s_ready=0 expected 1 within 200 cycles");
            end else begin
                exp_b.push_back(pk(16'(b_s_data), 1'b0, 1'b0));
                if (b_s_last)
                    for (int k = 0; k < 4; k++)
                        exp_b.push_back(pk(16'(crc[31 - 8*k -: 8]), k == 3, 1'b1));
            end
            @(posedge clk); #1;
            b_s_valid = 1'b0;
            b_s_last  = 1'b0;
        end
    endtask

    task automatic send_c(input int len, input logic [63:0] words, input logic [15:0] crc);
        bit ok;
        for (int i = 0; i < len; i++) begin
            c_s_valid = 1'b1;
            c_s_data  = words[63 - 16*i -: 16];
            c_s_last  = (i == len - 1);
            ok = 1'b0;
            for (int w = 0; w < 200 && !ok; w++) begin
                @(negedge clk);
                ok = c_s_ready;
                if (!ok) begin @(posedge clk); #1; end
            end
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL c_input_timeout: got s_ready=0 expected 1 within 200 cycles");
            end else begin
                exp_c.push_back(pk(c_s_data, 1'b0, 1'b0));
                if (c_s_last) exp_c.push_back(pk(crc, 1'b1, 1'b1));
            end
            @(posedge clk); #1;
            c_s_valid = 1'b0;
            c_s_last  = 1'b0;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_a.size() + exp_b.size() + exp_c.size()) != 0 && w < 1000) begin
            @(posedge clk); #1;
            w++;
        end
        check("drain_outstanding_beats", 32'(exp_a.size() + exp_b.size() + exp_c.size()), 32'd0);
    endtask

    localparam logic [71:0] STR9 = 72'h31_32_33_34_35_36_37_38_39;

    initial begin
        vecs[0] = '{9, STR9, 16'h29B1, 1'b0, 1'b1};
        vecs[1] = '{1, {8'h00, 64'h0}, 16'hE1F0, 1'b0, 1'b0};
        vecs[2] = '{1, {8'h00, 64'h0}, 16'hE1F0, 1'b0, 1'b1};
        vecs[3] = '{9, STR9, 16'h29B1, 1'b1, 1'b1};
        vecs[4] = '{3, {24'hA5_5A_FF, 48'h0}, 16'h0, 1'b1, 1'b1};
        vecs[5] = '{2, {16'hC3_3C, 56'h0}, 16'h0, 1'b1, 1'b1};
        vecs[4].crc = ccitt_model(3, vecs[4].bytes);
        vecs[5].crc = ccitt_model(2, vecs[5].bytes);

        #12;
        check("rst_a_outputs", 32'({a_m_valid, a_m_last, a_m_is_crc, a_m_data}), 32'd0);
        check("rst_a_s_ready", 32'(a_s_ready), 32'd1);
        check("rst_bc_m_valid", 32'({b_m_valid, c_m_valid}), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 6; v++) begin
            a_rand = vecs[v].gaps;
            send_a(vecs[v].len, vecs[v].bytes, vecs[v].crc, vecs[v].gaps, 1'b0);
            if (vecs[v].drain) begin
                drain();
                if (!vecs[v].gaps)
                    check("a_packet_cycles", 32'(a_last_pop_cyc - a_t0), 32'(vecs[v].len + 2));
            end
        end

        // Reset between clock edges with a packet half sent.
        a_rand = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        send_a(4, STR9, 16'h0, 1'b0, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_a_outputs", 32'({a_m_valid, a_m_last, a_m_is_crc, a_m_data}), 32'd0);
        check("midrst_a_s_ready", 32'(a_s_ready), 32'd1);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        send_a(9, STR9, 16'h29B1, 1'b0, 1'b0);
        drain();
        check("a_packet_cycles_after_reset", 32'(a_last_pop_cyc - a_t0), 32'd11);

        send_b(9, STR9, 32'hFC89_1918);
        drain();

        send_c(4, 64'h3132_3334_3536_3738, ccitt_model(8, {64'h3132_3334_3536_3738, 8'h0}));
        drain();
        send_c(2, {32'hFFFF_0001, 32'h0}, ccitt_model(4, {32'hFFFF_0001, 40'h0}));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
